// File: rtl/nibble_field_packer.sv
// nibble_field_packer
// Collects 4-bit writes into an 80-bit word W[83:4]. Each write lands at a bit
// anchor, either ascending ("+:") or descending ("-:"). Bits that fall outside
// 4..83 are dropped and counted. A write marked last closes the frame. The word
// is then serialized as 20 nibbles, lowest first, over a valid/ready port.
//
// Ports
//   clk        sole clock, all state on posedge
//   reset_l    synchronous active-low reset
//   wr_valid   write request valid
//   wr_ready   packer accepts a write this cycle (IDLE/LOAD)
//   wr_bitn    anchor bit index 0..127 into W[83:4]
//   wr_minus   0 = ascending from anchor, 1 = descending (nib[3] at anchor)
//   wr_nib     nibble data
//   wr_last    this write closes the frame
//   rd_valid   serialized nibble valid (DRAIN)
//   rd_ready   consumer accepts nibble
//   rd_nib     serialized nibble, beat k = W[4+4k +: 4]
//   rd_last    final nibble of frame (k == 19)
//   rd_word    word register, bit 0 = W[4]
//   trunc_cnt  writes with at least one dropped bit, saturating at 255
module nibble_field_packer #(
    parameter int unsigned CLEAR_ON_START = 1
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_bitn,
    input  logic        wr_minus,
    input  logic [3:0]  wr_nib,
    input  logic        wr_last,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [3:0]  rd_nib,
    output logic        rd_last,
    output logic [79:0] rd_word,
    output logic [7:0]  trunc_cnt
);

    localparam int unsigned WORD_W  = 80;
    localparam int unsigned BEAT_W  = 5;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NIB_W   = 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(19);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    // Targets are computed signed and wider than the anchor so that a
    // descending write near 0 goes negative instead of wrapping.
    localparam logic signed [8:0] IDX_LO = 9'sd4;
    localparam logic signed [8:0] IDX_HI = 9'sd83;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   word_next;
    logic [BEAT_W-1:0]   beat;
    logic [CNT_W-1:0]    trunc;
    logic                drop;
    logic                wr_xfer;
    logic                rd_xfer;
    logic signed [8:0]   tgt;
    logic [6:0]          idx;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/serializer outputs
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_nib     = '0;
        rd_last    = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    state_next = wr_last ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid && wr_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                rd_valid = 1'b1;
                rd_nib   = word[{beat, 2'b00} +: NIB_W];
                rd_last  = (beat == LAST_BEAT);
                if (rd_ready && rd_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wr_xfer = wr_valid && wr_ready;
    assign rd_xfer = rd_valid && rd_ready;

    // Merge the incoming nibble into the (optionally cleared) word
    always_comb begin
        word_next = ((state == IDLE) && (CLEAR_ON_START != 0)) ? '0 : word;
        drop      = 1'b0;
        tgt       = '0;
        idx       = '0;
        for (int i = 0; i < NIB_W; i++) begin
            tgt = 9'({2'b00, wr_bitn}) + 9'(i) - (wr_minus ? 9'd3 : 9'd0);
            if ((tgt >= IDX_LO) && (tgt <= IDX_HI)) begin
                idx            = 7'(tgt - IDX_LO);
                word_next[idx] = wr_nib[2'(i)];
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Word, beat index and truncation counter
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            word  <= '0;
            beat  <= '0;
            trunc <= '0;
        end else begin
            if (wr_xfer) begin
                word <= word_next;
                if (drop && (trunc != CNT_MAX)) begin
                    trunc <= trunc + CNT_W'(1);
                end
            end
            if (rd_xfer) begin
                beat <= rd_last ? '0 : beat + BEAT_W'(1);
            end
        end
    end

    assign rd_word   = word;
    assign trunc_cnt = trunc;

endmodule

// File: tb/tb_nibble_field_packer.sv
// Bench for nibble_field_packer: directed writes with hand-computed words;
// expected serialized beats are queued and checked by an independent monitor.
module tb_nibble_field_packer;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        wr_valid;
    logic        wr_ready;
    logic [6:0]  wr_bitn;
    logic        wr_minus;
    logic [3:0]  wr_nib;
    logic        wr_last;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  rd_nib;
    logic        rd_last;
    logic [79:0] rd_word;
    logic [7:0]  trunc_cnt;

    logic        nc_wr_ready;
    logic        nc_rd_valid;
    logic [3:0]  nc_rd_nib;
    logic        nc_rd_last;
    logic [79:0] nc_rd_word;
    logic [7:0]  nc_trunc_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    nibble_field_packer u_dut (
        .clk(clk), .reset_l(reset_l), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_bitn(wr_bitn), .wr_minus(wr_minus), .wr_nib(wr_nib), .wr_last(wr_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_nib(rd_nib), .rd_last(rd_last),
        .rd_word(rd_word), .trunc_cnt(trunc_cnt)
    );

    nibble_field_packer #(.CLEAR_ON_START(0)) u_dut_nc (
        .clk(clk), .reset_l(reset_l), .wr_valid(wr_valid), .wr_ready(nc_wr_ready),
        .wr_bitn(wr_bitn), .wr_minus(wr_minus), .wr_nib(wr_nib), .wr_last(wr_last),
        .rd_valid(nc_rd_valid), .rd_ready(rd_ready), .rd_nib(nc_rd_nib), .rd_last(nc_rd_last),
        .rd_word(nc_rd_word), .trunc_cnt(nc_trunc_cnt)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the 20 beats that a frame holding this word must produce
    task automatic push_frame(input logic [79:0] w);
        for (int k = 0; k < 20; k++) begin
            sb.push_back({(k == 19), w[4*k +: 4]});
        end
    endtask

    // One write transfer; caller is in a cycle where wr_ready is expected
    task automatic do_write(input logic [6:0] bitn, input logic minus,
                            input logic [3:0] nib, input logic last);
        wr_bitn  = bitn;
        wr_minus = minus;
        wr_nib   = nib;
        wr_last  = last;
        wr_valid = 1'b1;
        @(negedge clk);
        check("wr_ready_on_write", 80'(wr_ready), 80'h1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Consume n beats with rd_ready high; bounded
    task automatic read_beats(input int n);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 200) begin
            rd_ready = 1'b1;
            @(negedge clk);
            if (rd_valid) got++;
            @(posedge clk); #1;
            guard++;
        end
        rd_ready = 1'b0;
        if (got < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_beats_timeout: got %0d beats expected %0d", got, n);
        end
    endtask

    // Scoreboard monitor: pop and compare on every read transfer
    always @(negedge clk) begin
        if (reset_l && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got nib 0x%0h last %0b expected none", rd_nib, rd_last);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                check("beat_nib", 80'(rd_nib), 80'(e[3:0]));
                check("beat_last", 80'(rd_last), 80'(e[4]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] w;
        reset_l  = 1'b0;
        wr_valid = 1'b0;
        wr_bitn  = '0;
        wr_minus = 1'b0;
        wr_nib   = '0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", 80'(rd_valid), 80'h0);
        check("rst_rd_word", rd_word, 80'h0);
        check("rst_trunc", 80'(trunc_cnt), 80'h0);
        check("rst_wr_ready", 80'(wr_ready), 80'h1);
        check("rst_rd_nib", 80'(rd_nib), 80'h0);
        check("rst_rd_last", 80'(rd_last), 80'h0);
        reset_l = 1'b1;
        @(posedge clk); #1;

        // Ascending write at bit 7: W[10:7]=1010 -> rd_word bits 6..3
        push_frame(80'h50);
        do_write(7'd7, 1'b0, 4'hA, 1'b1);
        check("t1_word", rd_word, 80'h50);
        check("t1_rd_valid_latency", 80'(rd_valid), 80'h1);
        check("t1_wr_ready_drain", 80'(wr_ready), 80'h0);
        check("t1_trunc", 80'(trunc_cnt), 80'h0);
        read_beats(20);
        check("t1_rd_valid_after", 80'(rd_valid), 80'h0);
        check("t1_wr_ready_after", 80'(wr_ready), 80'h1);
        check("t1_word_retained", rd_word, 80'h50);

        // Partially/fully out-of-range writes
        do_write(7'd4, 1'b1, 4'hF, 1'b0);
        check("t2_minus_low_word", rd_word, 80'h1);
        check("t2_minus_low_trunc", 80'(trunc_cnt), 80'd1);
        do_write(7'd83, 1'b0, 4'h9, 1'b0);
        check("t2_plus_high_word", rd_word, (80'h1 << 79) | 80'h1);
        check("t2_plus_high_trunc", 80'(trunc_cnt), 80'd2);
        do_write(7'd127, 1'b0, 4'hF, 1'b0);
        check("t2_oob_word", rd_word, (80'h1 << 79) | 80'h1);
        check("t2_oob_trunc", 80'(trunc_cnt), 80'd3);
        w = (80'h1 << 79) | (80'h6 << 36) | 80'h1;
        push_frame(w);
        do_write(7'd40, 1'b0, 4'h6, 1'b1);
        check("t2_word", rd_word, w);
        check("t2_trunc", 80'(trunc_cnt), 80'd3);
        read_beats(9);
        // Stall on beat 9 (nibble 6) and poke writes that must be ignored
        for (int s = 0; s < 5; s++) begin
            wr_valid = (s == 1 || s == 2);
            wr_bitn  = 7'd4;
            wr_minus = 1'b0;
            wr_nib   = 4'hF;
            wr_last  = 1'b1;
            @(negedge clk);
            check("stall_rd_nib", 80'(rd_nib), 80'h6);
            check("stall_rd_valid", 80'(rd_valid), 80'h1);
            check("stall_rd_last", 80'(rd_last), 80'h0);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check("drain_ignore_word", rd_word, w);
        check("drain_ignore_trunc", 80'(trunc_cnt), 80'd3);
        read_beats(11);
        check("t2_rd_valid_after", 80'(rd_valid), 80'h0);

        // Saturation of trunc_cnt
        do_write(7'd20, 1'b0, 4'hC, 1'b0);
        check("t3_word", rd_word, 80'hC0000);
        do_write(7'd127, 1'b0, 4'hF, 1'b0);
        check("t3_oob_word", rd_word, 80'hC0000);
        check("t3_oob_trunc", 80'(trunc_cnt), 80'd4);
        for (int n = 0; n < 255; n++) do_write(7'd127, 1'b0, 4'hF, 1'b0);
        check("t3_trunc_sat", 80'(trunc_cnt), 80'd255);
        push_frame(80'hC0000);
        do_write(7'd0, 1'b0, 4'hF, 1'b1);
        check("t3_trunc_sat_hold", 80'(trunc_cnt), 80'd255);
        check("t3_word_final", rd_word, 80'hC0000);
        read_beats(20);

        // Reset in the middle of a drain
        push_frame(80'h7 << 56);
        do_write(7'd60, 1'b0, 4'h7, 1'b1);
        check("t4_word", rd_word, 80'h7 << 56);
        read_beats(10);
        reset_l = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        check("t4_rst_rd_valid", 80'(rd_valid), 80'h0);
        check("t4_rst_word", rd_word, 80'h0);
        check("t4_rst_trunc", 80'(trunc_cnt), 80'h0);
        check("t4_rst_wr_ready", 80'(wr_ready), 80'h1);
        reset_l  = 1'b1;
        rd_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("t4_no_partial_beats", 80'(rd_valid), 80'h0);
        end
        rd_ready = 1'b0;

        // Clear-on-start versus retain across frames
        push_frame(80'h3);
        do_write(7'd4, 1'b0, 4'h3, 1'b1);
        check("t5_f1_word", rd_word, 80'h3);
        check("t5_f1_word_nc", nc_rd_word, 80'h3);
        read_beats(20);
        push_frame(80'h50);
        do_write(7'd8, 1'b0, 4'h5, 1'b1);
        check("t5_f2_word", rd_word, 80'h50);
        check("t5_f2_word_nc", nc_rd_word, 80'h53);
        read_beats(20);

        repeat (2) @(posedge clk);
        check("sb_empty", 80'(sb.size()), 80'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
